// File: rtl/ram_fetch_if.sv
// rtl/ram_fetch_if.sv - command, RAM read port and output stream bundle for ram_fetch_ctrl
interface ram_fetch_if #(
    parameter int DW      = 8,
    parameter int ADDR_DW = 4,
    parameter int LEN_DW  = 5
);
    logic               start;
    logic [ADDR_DW-1:0] base_addr;
    logic [LEN_DW-1:0]  len;
    logic [ADDR_DW-1:0] stride;
    logic               ram_init;
    logic               RAenable;
    logic [ADDR_DW-1:0] addr;
    logic [DW-1:0]      din;
    logic               m_valid;
    logic               m_ready;
    logic [DW-1:0]      m_data;
    logic               m_last;
    logic               busy;
    logic               done;

    modport master (
        input  start, base_addr, len, stride, ram_init, din, m_ready,
        output RAenable, addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output start, base_addr, len, stride, ram_init, din, m_ready,
        input  RAenable, addr, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/ram_fetch_ctrl.sv
// rtl/ram_fetch_ctrl.sv - credit-limited RAM read initiator feeding a valid/ready output FIFO
module ram_fetch_ctrl #(
    parameter int DW         = 8,
    parameter int ADDR_DW    = 4,
    parameter int LEN_DW     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    ram_fetch_if.master   bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [ADDR_DW-1:0] addr_q, addr_d;
    logic [ADDR_DW-1:0] stride_q, stride_d;
    logic [LEN_DW-1:0]  len_q, len_d;
    logic [LEN_DW-1:0]  issued_q, issued_d;
    logic               pending_q, pending_d;
    logic               pend_last_q, pend_last_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;

    logic [DW-1:0]      fifo_data_q [FIFO_DEPTH];
    logic               fifo_last_q [FIFO_DEPTH];

    logic               ra_en;
    logic               pop;
    logic               credit_ok;
    logic               head_valid;
    logic               head_last;
    logic               last_issue;

    // Head of the FIFO; data and last are forced to zero while empty so stale entries never leak out
    assign head_valid    = (count_q != '0);
    assign head_last     = head_valid & fifo_last_q[rptr_q];
    assign pop           = head_valid & bus.m_ready;
    assign credit_ok     = ({1'b0, count_q} + (CNT_W+1)'(pending_q)) < (CNT_W+1)'(FIFO_DEPTH);
    assign last_issue    = (issued_q == len_q - LEN_DW'(1));

    assign bus.RAenable  = ra_en;
    assign bus.addr      = addr_q;
    assign bus.m_valid   = head_valid;
    assign bus.m_data    = head_valid ? fifo_data_q[rptr_q] : '0;
    assign bus.m_last    = head_last;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

    // Next-state, read issue and FIFO bookkeeping
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        len_d       = len_q;
        issued_d    = issued_q;
        pend_last_d = 1'b0;
        done_d      = 1'b0;
        ra_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.ram_init) begin
                    if (bus.len != '0) begin
                        len_d    = bus.len;
                        stride_d = bus.stride;
                        addr_d   = bus.base_addr;
                        issued_d = '0;
                        state_d  = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                // At most one read in flight and never more reads than free FIFO slots
                ra_en = !bus.ram_init && credit_ok;
                if (ra_en) begin
                    addr_d      = addr_q + stride_q;
                    issued_d    = issued_q + LEN_DW'(1);
                    pend_last_d = last_issue;
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = ra_en;
        wptr_d    = pending_q ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d    = pop ? rptr_q + PTR_W'(1) : rptr_q;
        count_d   = count_q + CNT_W'(pending_q) - CNT_W'(pop);
    end

    // Control and pointer registers; reset discards any pending read and empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            pending_q   <= pending_d;
            pend_last_q <= pend_last_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage: capture the RAM word one cycle after its read was issued
    always_ff @(posedge clk) begin
        if (pending_q) begin
            fifo_data_q[wptr_q] <= bus.din;
            fifo_last_q[wptr_q] <= pend_last_q;
        end
    end
endmodule

// File: tb/tb_ram_fetch_ctrl.sv
// tb/tb_ram_fetch_ctrl.sv - scoreboard bench for ram_fetch_ctrl with a behavioural RAM
module tb_ram_fetch_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LW    = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_fetch_if #(.DW(DW), .ADDR_DW(AW), .LEN_DW(LW)) bus ();

    ram_fetch_ctrl #(.DW(DW), .ADDR_DW(AW), .LEN_DW(LW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] ram_dout;
    always @(posedge clk) if (bus.RAenable) ram_dout <= ram_mem[bus.addr];
    assign bus.din = ram_dout;

    int vectors    = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];
    bit            exp_last_q [$];
    bit            mbusy = 0;
    bit            exp_done = 0;
    bit            post_rst = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    int            ren_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected by reference at %0t", name, $time);
    endtask

    // Monitor and reference model: observes at negedge, values are those the next edge will use
    always @(negedge clk) begin
        if (rst) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            exp_last_q.delete();
            mbusy      = 0;
            exp_done   = 0;
            stall_prev = 0;
            post_rst   = 1;
        end else begin
            if (post_rst) begin
                check("rst_addr",     bus.addr,     0);
                check("rst_m_valid",  bus.m_valid,  0);
                check("rst_m_data",   bus.m_data,   0);
                check("rst_m_last",   bus.m_last,   0);
                check("rst_busy",     bus.busy,     0);
                check("rst_done",     bus.done,     0);
                check("rst_RAenable", bus.RAenable, 0);
                post_rst = 0;
            end
            check("busy", bus.busy, mbusy);
            check("done", bus.done, exp_done);
            exp_done = 0;
            if (bus.ram_init) check("ren_during_init", bus.RAenable, 0);
            if (bus.RAenable) begin
                ren_count++;
                if (exp_addr_q.size() == 0) fail_now("extra_read");
                else check("addr", bus.addr, exp_addr_q.pop_front());
            end
            if (stall_prev) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_data",  bus.m_data,  stall_data);
                check("hold_last",  bus.m_last,  stall_last);
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            stall_data = bus.m_data;
            stall_last = bus.m_last;
            if (bus.start && !bus.ram_init && !mbusy) begin
                if (bus.len == 0) begin
                    exp_done = 1;
                end else begin
                    mbusy = 1;
                    for (int i = 0; i < int'(bus.len); i++) begin
                        logic [AW-1:0] a;
                        a = AW'(int'(bus.base_addr) + i * int'(bus.stride));
                        exp_addr_q.push_back(a);
                        exp_data_q.push_back(ram_mem[a]);
                        exp_last_q.push_back(i == int'(bus.len) - 1);
                    end
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_data_q.size() == 0) begin
                    fail_now("extra_beat");
                end else begin
                    bit l;
                    l = exp_last_q.pop_front();
                    check("m_data", bus.m_data, exp_data_q.pop_front());
                    check("m_last", bus.m_last, l);
                    if (l) begin
                        mbusy    = 0;
                        exp_done = 1;
                    end
                end
            end
        end
    end

    task automatic issue_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [AW-1:0] s);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.len       = l;
        bus.stride    = s;
        bus.ram_init  = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input bit randomize);
        int n;
        n = 0;
        while (mbusy || exp_data_q.size() != 0 || exp_done) begin
            @(posedge clk);
            #1;
            if (randomize) begin
                bus.m_ready  = ($urandom_range(3) != 0);
                bus.ram_init = ($urandom_range(7) == 0);
            end
            n++;
            if (n > 3000) begin
                fail_now("idle_timeout");
                break;
            end
        end
        bus.ram_init = 1'b0;
    endtask

    task automatic timed_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [AW-1:0] s);
        int k;
        issue_cmd(b, l, s);
        @(negedge clk); check("lat_valid_e0", bus.m_valid, 0);
        @(negedge clk); check("lat_valid_e1", bus.m_valid, 0);
        @(negedge clk); check("lat_valid_e2", bus.m_valid, 1);
        k = 2;
        while (!bus.done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("done_latency", k, int'(l) + 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = DW'($urandom);
        ram_mem[0]  = 8'h01; ram_mem[1] = 8'hFC; ram_mem[2] = 8'hFE; ram_mem[3] = 8'h01;
        ram_mem[14] = 8'hFD; ram_mem[8] = 8'h00;

        rst = 1'b1;
        bus.start = 0; bus.base_addr = 0; bus.len = 0; bus.stride = 0;
        bus.ram_init = 0; bus.m_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        bus.m_ready = 1'b1;
        timed_cmd(4'd0, 5'd4, 4'd1);
        wait_idle(0);
        timed_cmd(4'd14, 5'd3, 4'd5);
        wait_idle(0);

        bus.m_ready = 1'b0;
        @(posedge clk); #1;
        issue_cmd(4'd4, 5'd10, 4'd3);
        ren_count = 0;
        repeat (8) @(negedge clk);
        #1;
        check("bp_reads", ren_count, 4);
        check("bp_ren_low", bus.RAenable, 0);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        wait_idle(0);

        issue_cmd(4'd5, 5'd8, 4'd3);
        repeat (2) @(posedge clk);
        #1 bus.ram_init = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.ram_init = 1'b0;
        wait_idle(0);

        issue_cmd(4'd7, 5'd0, 4'd2);
        wait_idle(0);
        issue_cmd(4'd1, 5'd6, 4'd2);
        @(posedge clk); #1;
        issue_cmd(4'd9, 5'd3, 4'd1);
        wait_idle(0);

        bus.m_ready = 1'b0;
        @(posedge clk); #1;
        issue_cmd(4'd2, 5'd10, 4'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        issue_cmd(4'd11, 5'd5, 4'd7);
        wait_idle(0);

        for (int c = 0; c < 25; c++) begin
            issue_cmd(AW'($urandom), LW'($urandom), AW'($urandom));
            wait_idle(1);
            bus.m_ready = 1'b1;
        end

        repeat (3) @(posedge clk);
        check("leftover_beats", exp_data_q.size(), 0);
        check("leftover_reads", exp_addr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
